// File: rtl/usb_ep_array_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : usb_ep_array_pkg
//  Description : Shared handshake encoding, CPU register offsets and control
//                bit positions for the USB endpoint array.
//  Revision    : 1.0 - initial release
// ============================================================================
package usb_ep_array_pkg;

    // Handshake codes presented to the usb core
    typedef enum logic [1:0] {
        HS_ACK   = 2'b00,
        HS_NONE  = 2'b01,
        HS_NAK   = 2'b10,
        HS_STALL = 2'b11
    } hs_e;

    // CPU register offsets within a pipe window
    localparam logic [1:0] C_REG_CTRL = 2'd0;
    localparam logic [1:0] C_REG_LEN0 = 2'd2;
    localparam logic [1:0] C_REG_LEN1 = 2'd3;

    // reg0 write bit positions
    localparam int C_BIT_ARM0      = 0;
    localparam int C_BIT_ARM1      = 1;
    localparam int C_BIT_SET_STALL = 2;
    localparam int C_BIT_CLR_STALL = 3;
    localparam int C_BIT_CLR_TOG   = 4;
    localparam int C_BIT_CLR_SETUP = 5;
    localparam int C_BIT_ENABLE    = 6;
    localparam int C_BIT_DISABLE   = 7;

endpackage : usb_ep_array_pkg
`default_nettype wire

// File: rtl/usb_ep_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : usb_ep_pipe
//  Description : State of one endpoint pipe (one endpoint, one direction):
//                double-bank ownership, current bank, bank lengths, data
//                toggle, stall, setup flag and per-bank done flags.
//  Ports       : complete    - ACKed transaction finished on this pipe
//                setup_done  - ACKed SETUP finished on this pipe's endpoint
//                cnt         - byte count of the finishing OUT transaction
//                ctrl_wr     - CPU reg0 write, ctrl_data carries bits [5:0]
//                len0_wr/len1_wr - CPU length writes, len_data is the value
//                release_all - endpoint disable: both banks back to the CPU
//                own..done   - current state, read by the top level
//  Revision    : 1.0 - initial release
// ============================================================================
module usb_ep_pipe
    import usb_ep_array_pkg::*;
#(
    parameter int CNT_W = 7,
    parameter bit IS_IN = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             complete,
    input  logic             setup_done,
    input  logic [CNT_W-1:0] cnt,
    input  logic             ctrl_wr,
    input  logic [5:0]       ctrl_data,
    input  logic             len0_wr,
    input  logic             len1_wr,
    input  logic [CNT_W-1:0] len_data,
    input  logic             release_all,
    output logic [1:0]       own,
    output logic             cur,
    output logic [CNT_W-1:0] len0,
    output logic [CNT_W-1:0] len1,
    output logic             tog,
    output logic             stall,
    output logic             setup_flag,
    output logic [1:0]       done
);

    logic [1:0]       r_own,   w_own_n;
    logic             r_cur,   w_cur_n;
    logic [CNT_W-1:0] r_len0,  w_len0_n;
    logic [CNT_W-1:0] r_len1,  w_len1_n;
    logic             r_tog,   w_tog_n;
    logic             r_stall, w_stall_n;
    logic             r_setup, w_setup_n;
    logic [1:0]       r_done,  w_done_n;

    // Updates are applied in ascending priority; later assignments win.
    always_comb begin
        w_own_n   = r_own;
        w_cur_n   = r_cur;
        w_len0_n  = r_len0;
        w_len1_n  = r_len1;
        w_tog_n   = r_tog;
        w_stall_n = r_stall;
        w_setup_n = r_setup;
        w_done_n  = r_done;

        // Arming looks at ownership before this cycle, so a bank that the
        // USB side releases in the same cycle stays CPU-owned.
        if (ctrl_wr) begin
            if (ctrl_data[C_BIT_ARM0] && !r_own[0]) begin
                w_own_n[0]  = 1'b1;
                w_done_n[0] = 1'b0;
            end
            if (ctrl_data[C_BIT_ARM1] && !r_own[1]) begin
                w_own_n[1]  = 1'b1;
                w_done_n[1] = 1'b0;
            end
            if (ctrl_data[C_BIT_CLR_STALL]) w_stall_n = 1'b0;
            if (ctrl_data[C_BIT_SET_STALL]) w_stall_n = 1'b1;
            if (ctrl_data[C_BIT_CLR_SETUP]) w_setup_n = 1'b0;
        end
        if (len0_wr) w_len0_n = len_data;
        if (len1_wr) w_len1_n = len_data;

        if (complete) begin
            w_own_n[r_cur]  = 1'b0;
            w_done_n[r_cur] = 1'b1;
            w_cur_n         = ~r_cur;
            w_tog_n         = ~r_tog;
            // Received length, overflow bit included
            if (!IS_IN) begin
                if (r_cur) w_len1_n = cnt;
                else       w_len0_n = cnt;
            end
        end

        // SETUP resynchronises both directions to DATA1 and clears stall
        if (setup_done) begin
            w_tog_n   = 1'b1;
            w_stall_n = 1'b0;
            if (!IS_IN) w_setup_n = 1'b1;
        end

        if (ctrl_wr && ctrl_data[C_BIT_CLR_TOG]) w_tog_n = 1'b0;
        if (release_all) w_own_n = 2'b00;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_own   <= 2'b00;
            r_cur   <= 1'b0;
            r_len0  <= '0;
            r_len1  <= '0;
            r_tog   <= 1'b0;
            r_stall <= 1'b0;
            r_setup <= 1'b0;
            r_done  <= 2'b00;
        end else begin
            r_own   <= w_own_n;
            r_cur   <= w_cur_n;
            r_len0  <= w_len0_n;
            r_len1  <= w_len1_n;
            r_tog   <= w_tog_n;
            r_stall <= w_stall_n;
            r_setup <= w_setup_n;
            r_done  <= w_done_n;
        end
    end

    assign own        = r_own;
    assign cur        = r_cur;
    assign len0       = r_len0;
    assign len1       = r_len1;
    assign tog        = r_tog;
    assign stall      = r_stall;
    assign setup_flag = r_setup;
    assign done       = r_done;

endmodule : usb_ep_pipe
`default_nettype wire

// File: rtl/usb_ep_array.sv
`default_nettype none
// ============================================================================
//  Module      : usb_ep_array
//  Description : NUM_EP endpoints x {OUT, IN} double-banked endpoint
//                controller. Selects the active pipe combinationally from
//                endpoint/direction_in, produces handshake/toggle/bank/
//                in_data_valid for the usb core and a CPU register window.
//  Ports       : endpoint, direction_in, setup, success, cnt - usb core side
//                toggle, handshake, bank, in_data_valid         - to usb core
//                ctrl_addr {ep,dir,reg}, ctrl_wr_strobe, ctrl_wr_data,
//                ctrl_rd_data                                   - CPU window
//                pending[{ep,dir}] - pipe has a filled/freed CPU-owned bank
//  Revision    : 1.0 - initial release
// ============================================================================
module usb_ep_array
    import usb_ep_array_pkg::*;
#(
    parameter int          NUM_EP      = 4,
    parameter int          CNT_W       = 7,
    parameter logic [15:0] ENABLE_MASK = 16'h0001
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          endpoint,
    input  logic                direction_in,
    input  logic                setup,
    input  logic                success,
    input  logic [CNT_W-1:0]    cnt,
    output logic                toggle,
    output logic [1:0]          handshake,
    output logic                bank,
    output logic                in_data_valid,
    input  logic [6:0]          ctrl_addr,
    input  logic                ctrl_wr_strobe,
    input  logic [15:0]         ctrl_wr_data,
    output logic [15:0]         ctrl_rd_data,
    output logic [2*NUM_EP-1:0] pending
);

    localparam int C_NPIPE = 2 * NUM_EP;

    // Per-pipe state collected from the pipe instances
    logic [1:0]       w_own   [C_NPIPE];
    logic [1:0]       w_done  [C_NPIPE];
    logic [CNT_W-1:0] w_len0  [C_NPIPE];
    logic [CNT_W-1:0] w_len1  [C_NPIPE];
    logic [C_NPIPE-1:0] w_cur, w_tog, w_stall, w_setup_flag;

    logic [NUM_EP-1:0] r_enable;

    // usb core side selection
    logic [4:0]       w_sel_idx;
    logic             w_ep_valid;
    logic             w_s_en;
    logic [1:0]       w_s_own;
    logic             w_s_cur, w_s_tog, w_s_stall, w_s_own_cur;
    logic [CNT_W-1:0] w_s_len_cur;
    hs_e              w_hs;
    logic             w_ack_done;

    // CPU side decode
    logic [3:0]       w_cpu_ep;
    logic [4:0]       w_cpu_idx;
    logic [1:0]       w_cpu_reg;
    logic             w_cpu_valid;
    logic             w_cpu_ctrl;
    logic             w_unused;

    assign w_sel_idx  = {endpoint, direction_in};
    assign w_ep_valid = ({1'b0, endpoint} < 5'(NUM_EP));

    assign w_cpu_ep    = ctrl_addr[6:3];
    assign w_cpu_idx   = ctrl_addr[6:2];
    assign w_cpu_reg   = ctrl_addr[1:0];
    assign w_cpu_valid = ({1'b0, w_cpu_ep} < 5'(NUM_EP));
    assign w_cpu_ctrl  = ctrl_wr_strobe && w_cpu_valid && (w_cpu_reg == C_REG_CTRL);
    assign w_unused    = ^ctrl_wr_data;

    // Selected pipe; an out-of-range index matches nothing and reads zero
    always_comb begin
        w_s_en      = 1'b0;
        w_s_own     = 2'b00;
        w_s_cur     = 1'b0;
        w_s_tog     = 1'b0;
        w_s_stall   = 1'b0;
        w_s_len_cur = '0;
        for (int p = 0; p < C_NPIPE; p++) begin
            if (w_sel_idx == 5'(p)) begin
                w_s_own     = w_own[p];
                w_s_cur     = w_cur[p];
                w_s_tog     = w_tog[p];
                w_s_stall   = w_stall[p];
                w_s_len_cur = w_cur[p] ? w_len1[p] : w_len0[p];
            end
        end
        for (int e = 0; e < NUM_EP; e++) begin
            if (endpoint == 4'(e)) w_s_en = r_enable[e];
        end
    end

    assign w_s_own_cur = w_s_cur ? w_s_own[1] : w_s_own[0];

    always_comb begin
        w_hs = HS_ACK;
        if (!w_ep_valid || !w_s_en)      w_hs = HS_STALL;
        else if (setup && !w_s_own_cur)  w_hs = HS_NONE;
        else if (setup)                  w_hs = HS_ACK;
        else if (w_s_stall)              w_hs = HS_STALL;
        else if (!w_s_own_cur)           w_hs = HS_NAK;
        else                             w_hs = HS_ACK;
    end

    // Only transactions this block actually ACKed may update pipe state
    assign w_ack_done = success && (w_hs == HS_ACK);

    assign handshake     = w_hs;
    assign toggle        = w_s_tog;
    assign bank          = w_s_cur;
    assign in_data_valid = direction_in && (cnt < w_s_len_cur);

    generate
        for (genvar p = 0; p < C_NPIPE; p++) begin : g_pipe
            localparam int C_EP = p / 2;
            logic w_is_cpu;

            assign w_is_cpu = ctrl_wr_strobe && w_cpu_valid && (w_cpu_idx == 5'(p));

            usb_ep_pipe #(
                .CNT_W (CNT_W),
                .IS_IN ((p % 2) == 1)
            ) u_pipe (
                .clk         (clk),
                .rst         (rst),
                .complete    (w_ack_done && (w_sel_idx == 5'(p))),
                .setup_done  (w_ack_done && setup && (endpoint == 4'(C_EP))),
                .cnt         (cnt),
                .ctrl_wr     (w_is_cpu && (w_cpu_reg == C_REG_CTRL)),
                .ctrl_data   (ctrl_wr_data[5:0]),
                .len0_wr     (w_is_cpu && (w_cpu_reg == C_REG_LEN0)),
                .len1_wr     (w_is_cpu && (w_cpu_reg == C_REG_LEN1)),
                .len_data    (ctrl_wr_data[CNT_W-1:0]),
                .release_all (w_cpu_ctrl && (w_cpu_ep == 4'(C_EP))
                              && ctrl_wr_data[C_BIT_DISABLE]),
                .own         (w_own[p]),
                .cur         (w_cur[p]),
                .len0        (w_len0[p]),
                .len1        (w_len1[p]),
                .tog         (w_tog[p]),
                .stall       (w_stall[p]),
                .setup_flag  (w_setup_flag[p]),
                .done        (w_done[p])
            );

            assign pending[p] = |(w_done[p] & ~w_own[p]);
        end
    endgenerate

    // Endpoint enables; disable wins over a simultaneous enable
    always_ff @(posedge clk) begin
        if (rst) begin
            r_enable <= ENABLE_MASK[NUM_EP-1:0];
        end else if (w_cpu_ctrl) begin
            for (int e = 0; e < NUM_EP; e++) begin
                if (w_cpu_ep == 4'(e)) begin
                    if (ctrl_wr_data[C_BIT_DISABLE])     r_enable[e] <= 1'b0;
                    else if (ctrl_wr_data[C_BIT_ENABLE]) r_enable[e] <= 1'b1;
                end
            end
        end
    end

    // CPU read window
    always_comb begin
        ctrl_rd_data = 16'h0000;
        for (int p = 0; p < C_NPIPE; p++) begin
            if (w_cpu_valid && (w_cpu_idx == 5'(p))) begin
                case (w_cpu_reg)
                    C_REG_CTRL: ctrl_rd_data = {8'h00, r_enable[p/2], w_setup_flag[p],
                                                w_stall[p], w_tog[p], w_cur[p],
                                                w_own[p][1], w_own[p][0], |w_done[p]};
                    C_REG_LEN0: ctrl_rd_data = 16'(w_len0[p]);
                    C_REG_LEN1: ctrl_rd_data = 16'(w_len1[p]);
                    default:    ctrl_rd_data = 16'h0000;
                endcase
            end
        end
    end

endmodule : usb_ep_array
`default_nettype wire

// File: tb/tb_usb_ep_array.sv
`default_nettype none
// ============================================================================
//  Module      : tb_usb_ep_array
//  Description : Directed self-checking bench for usb_ep_array (NUM_EP=4,
//                CNT_W=7, only endpoint 0 enabled after reset).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_ep_array;

    localparam logic [1:0] C_ACK   = 2'b00;
    localparam logic [1:0] C_NONE  = 2'b01;
    localparam logic [1:0] C_NAK   = 2'b10;
    localparam logic [1:0] C_STALL = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  endpoint;
    logic        direction_in;
    logic        setup;
    logic        success;
    logic [6:0]  cnt;
    logic        toggle;
    logic [1:0]  handshake;
    logic        bank;
    logic        in_data_valid;
    logic [6:0]  ctrl_addr;
    logic        ctrl_wr_strobe;
    logic [15:0] ctrl_wr_data;
    logic [15:0] ctrl_rd_data;
    logic [7:0]  pending;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    usb_ep_array #(
        .NUM_EP      (4),
        .CNT_W       (7),
        .ENABLE_MASK (16'h0001)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .endpoint       (endpoint),
        .direction_in   (direction_in),
        .setup          (setup),
        .success        (success),
        .cnt            (cnt),
        .toggle         (toggle),
        .handshake      (handshake),
        .bank           (bank),
        .in_data_valid  (in_data_valid),
        .ctrl_addr      (ctrl_addr),
        .ctrl_wr_strobe (ctrl_wr_strobe),
        .ctrl_wr_data   (ctrl_wr_data),
        .ctrl_rd_data   (ctrl_rd_data),
        .pending        (pending)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; checks follow 1 unit later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sel(input logic [3:0] ep, input logic din, input logic su);
        endpoint     = ep;
        direction_in = din;
        setup        = su;
        #1;
    endtask

    task automatic cpu_wr(input logic [6:0] a, input logic [15:0] d);
        ctrl_addr      = a;
        ctrl_wr_data   = d;
        ctrl_wr_strobe = 1'b1;
        step();
        ctrl_wr_strobe = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [6:0] a, input logic [15:0] exp);
        ctrl_addr = a;
        #1;
        chk(tag, ctrl_rd_data, exp);
    endtask

    task automatic xfer(input logic [6:0] c);
        cnt     = c;
        success = 1'b1;
        step();
        success = 1'b0;
    endtask

    initial begin
        rst = 1'b1; endpoint = 4'd0; direction_in = 1'b0; setup = 1'b0;
        success = 1'b0; cnt = 7'd0; ctrl_addr = 7'd0; ctrl_wr_strobe = 1'b0;
        ctrl_wr_data = 16'h0000;
        repeat (2) step();
        rst = 1'b0;
        step();

        // Reset state
        sel(4'd5, 1'b0, 1'b0);  chk("rst_ep5_stall", 16'(handshake), 16'(C_STALL));
        sel(4'd0, 1'b0, 1'b0);  chk("rst_ep0_nak",   16'(handshake), 16'(C_NAK));
        chk("rst_toggle", 16'(toggle), 16'h0);
        chk("rst_bank",   16'(bank),   16'h0);
        chk("rst_pending", 16'(pending), 16'h00);
        sel(4'd1, 1'b1, 1'b0);  chk("rst_ep1_stall", 16'(handshake), 16'(C_STALL));
        chk("rst_idv", 16'(in_data_valid), 16'h0);
        rd_chk("rst_ep0out_reg0", 7'h00, 16'h0080);

        // SETUP on ep0 with bank0 armed
        cpu_wr(7'h00, 16'h0001);
        sel(4'd0, 1'b0, 1'b1);  chk("setup_hs_ack", 16'(handshake), 16'(C_ACK));
        xfer(7'd8);
        rd_chk("setup_len0",     7'h02, 16'h0008);
        rd_chk("setup_out_reg0", 7'h00, 16'h00D9);
        rd_chk("setup_in_reg0",  7'h04, 16'h0090);
        chk("setup_pending", 16'(pending), 16'h01);
        chk("setup_unarmed_none", 16'(handshake), 16'(C_NONE));

        // ep1 IN: enable, len0=3, arm bank0, stream bytes
        sel(4'd1, 1'b1, 1'b0);
        cpu_wr(7'h08, 16'h0040);
        cpu_wr(7'h0E, 16'h0003);
        cpu_wr(7'h0C, 16'h0001);
        chk("in_hs_ack", 16'(handshake), 16'(C_ACK));
        for (int i = 0; i < 4; i++) begin
            cnt = 7'(i);
            #1;
            chk($sformatf("in_idv_cnt%0d", i), 16'(in_data_valid), (i < 3) ? 16'h1 : 16'h0);
        end
        xfer(7'd3);
        chk("in_done_toggle", 16'(toggle), 16'h1);
        chk("in_done_bank",   16'(bank),   16'h1);
        chk("in_done_nak",    16'(handshake), 16'(C_NAK));
        chk("in_done_pending", 16'(pending), 16'h09);

        // ep1 OUT overflow length, then unarmed bank1
        cpu_wr(7'h08, 16'h0001);
        sel(4'd1, 1'b0, 1'b0);
        xfer(7'h40);
        rd_chk("ovf_len0", 7'h0A, 16'h0040);
        chk("ovf_next_nak", 16'(handshake), 16'(C_NAK));
        chk("ovf_pending", 16'(pending), 16'h0D);

        // Back to bank0 with tog=0, then success + CPU write 0x11 same cycle
        cpu_wr(7'h08, 16'h0002);
        xfer(7'd5);
        cpu_wr(7'h08, 16'h0001);
        rd_chk("pre_same_reg0", 7'h08, 16'h0083);
        ctrl_addr      = 7'h08;
        ctrl_wr_data   = 16'h0011;
        ctrl_wr_strobe = 1'b1;
        cnt            = 7'd2;
        success        = 1'b1;
        step();
        ctrl_wr_strobe = 1'b0;
        success        = 1'b0;
        rd_chk("same_cycle_reg0", 7'h08, 16'h0089);
        rd_chk("same_cycle_len0", 7'h0A, 16'h0002);

        // Stall ep0 both dirs, then SETUP clears it (CPU stall-set same cycle)
        cpu_wr(7'h04, 16'h0014);
        cpu_wr(7'h00, 16'h0004);
        rd_chk("stall_in_reg0", 7'h04, 16'h00A0);
        sel(4'd0, 1'b1, 1'b0);  chk("stall_in_hs", 16'(handshake), 16'(C_STALL));
        cpu_wr(7'h00, 16'h0002);
        sel(4'd0, 1'b0, 1'b1);  chk("stall_setup_ack", 16'(handshake), 16'(C_ACK));
        ctrl_addr      = 7'h04;
        ctrl_wr_data   = 16'h0004;
        ctrl_wr_strobe = 1'b1;
        cnt            = 7'd8;
        success        = 1'b1;
        step();
        ctrl_wr_strobe = 1'b0;
        success        = 1'b0;
        rd_chk("setup2_in_reg0",  7'h04, 16'h0090);
        rd_chk("setup2_out_reg0", 7'h00, 16'h00D1);
        rd_chk("setup2_len1",     7'h03, 16'h0008);

        // Out-of-range CPU access, disable of ep1
        cpu_wr(7'h28, 16'h0041);
        rd_chk("ep5_read_zero", 7'h28, 16'h0000);
        cpu_wr(7'h0C, 16'h0002);
        cpu_wr(7'h08, 16'h0080);
        rd_chk("disable_in_reg0", 7'h0C, 16'h0019);
        sel(4'd1, 1'b1, 1'b0);  chk("disable_hs_stall", 16'(handshake), 16'(C_STALL));

        // Reset with a success in flight records nothing
        rst = 1'b1;
        sel(4'd0, 1'b0, 1'b0);
        cpu_wr(7'h00, 16'h0001);
        xfer(7'd4);
        rst = 1'b0;
        chk("rerst_pending", 16'(pending), 16'h00);
        rd_chk("rerst_ep0out_reg0", 7'h00, 16'h0080);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_usb_ep_array
`default_nettype wire
